// File: rtl/goe_mport.sv
// goe_mport -- multi-port packet replicator.
//
// A packet arrives one 134-bit word per cycle. The head word (tag 01) carries a
// destination bitmap in [111:104]. The head is only sent to ports that are
// requested and not full. That set of ports is the mask, and it is latched at
// the head. Every word of the packet, including the head, is then copied to the
// masked ports one cycle later.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   in_goe_data       packet word, tag in [133:132] (01 head, 11 body, 10 tail)
//   in_goe_data_wr    word valid
//   in_goe_valid      packet-good flag, qualified by in_goe_valid_wr
//   in_goe_valid_wr   end-of-packet status strobe (with the tail word)
//   pktout_usedw      per-port egress FIFO fill level, 8 bits per port
//   pktout_data       registered word, same value on every port
//   pktout_data_wr    per-port word strobe
//   pktout_valid      per-port packet-good flag
//   pktout_valid_wr   per-port end-of-packet strobe
//   pkt_out_cnt       per-port count of good packets forwarded
//   discard_cnt       per-port count of copies refused because the port was full
//   err_cnt           count of truncated packets (head arriving mid-packet)
//   dbg_state_o       current FSM state (0 idle, 1 fwd, 2 drop)
//
// Handshake: there is no back-pressure. A word is consumed in every cycle in
// which in_goe_data_wr=1. An output word is present in every cycle in which
// its port's pktout_data_wr=1. Both sides use valid-only strobes.
module goe_mport #(
  parameter int          PORT_NUM = 4,
  parameter logic [7:0]  USEDW_TH = 8'd160
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [133:0]             in_goe_data,
  input  logic                     in_goe_data_wr,
  input  logic                     in_goe_valid,
  input  logic                     in_goe_valid_wr,
  input  logic [PORT_NUM*8-1:0]    pktout_usedw,
  output logic [PORT_NUM*134-1:0]  pktout_data,
  output logic [PORT_NUM-1:0]      pktout_data_wr,
  output logic [PORT_NUM-1:0]      pktout_valid,
  output logic [PORT_NUM-1:0]      pktout_valid_wr,
  output logic [PORT_NUM*32-1:0]   pkt_out_cnt,
  output logic [PORT_NUM*32-1:0]   discard_cnt,
  output logic [31:0]              err_cnt,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PORT_NUM-1:0] mask_q, mask_d;

  logic [133:0]        data_q;
  logic [PORT_NUM-1:0] data_wr_q, valid_q, valid_wr_q;
  logic [31:0]         err_cnt_q;

  // Combinational strobes. Their registered copies become the outputs.
  logic [PORT_NUM-1:0] data_wr_d, valid_wr_d, valid_d, disc_inc;
  logic                err_inc;

  logic                is_head, is_tail;
  logic [PORT_NUM-1:0] req, full, new_mask;

  assign is_head = in_goe_data_wr && (in_goe_data[133:132] == 2'b01);
  assign is_tail = in_goe_data_wr && (in_goe_data[133:132] == 2'b10);
  // Bitmap bits at or above PORT_NUM name ports that do not exist. They are ignored.
  assign req     = in_goe_data[104 +: PORT_NUM];

  always_comb begin
    full = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      full[p] = (pktout_usedw[p*8 +: 8] >= USEDW_TH);
    end
  end

  assign new_mask = req & ~full;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state logic. The mask is loaded only at an accepted head, so any
  // change in fill level during the packet has no effect on it.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (is_head) begin
          mask_d  = new_mask;
          state_d = (|new_mask) ? S_FWD : S_DROP;
        end
      end
      S_FWD: begin
        // A head arriving here means the previous packet lost its tail.
        if (is_head)      state_d = S_DROP;
        else if (is_tail) state_d = S_IDLE;
      end
      S_DROP: begin
        if (is_tail) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    data_wr_d  = '0;
    valid_wr_d = '0;
    valid_d    = '0;
    disc_inc   = '0;
    err_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_head) begin
          disc_inc  = req & full;
          data_wr_d = new_mask;
        end
      end
      S_FWD: begin
        if (is_head) begin
          // Close the truncated packet on its ports with a bad status.
          // The new head itself is not forwarded.
          valid_wr_d = mask_q;
          err_inc    = 1'b1;
        end else begin
          if (in_goe_data_wr)  data_wr_d = mask_q;
          if (in_goe_valid_wr) begin
            valid_wr_d = mask_q;
            valid_d    = mask_q & {PORT_NUM{in_goe_valid}};
          end
        end
      end
      S_DROP: begin
        if (is_head) err_inc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      data_wr_q  <= '0;
      valid_q    <= '0;
      valid_wr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (|data_wr_d) data_q <= in_goe_data;
      data_wr_q  <= data_wr_d;
      valid_q    <= valid_d;
      valid_wr_q <= valid_wr_d;
      if (err_inc) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : gen_port
    logic [31:0] pkt_cnt_q;
    logic [31:0] disc_cnt_q;

    // Both counters wrap silently at 2^32.
    always_ff @(posedge clk) begin
      if (rst) begin
        pkt_cnt_q  <= '0;
        disc_cnt_q <= '0;
      end else begin
        if (valid_wr_d[p] && valid_d[p]) pkt_cnt_q <= pkt_cnt_q + 32'd1;
        if (disc_inc[p])                 disc_cnt_q <= disc_cnt_q + 32'd1;
      end
    end

    assign pkt_out_cnt[p*32 +: 32] = pkt_cnt_q;
    assign discard_cnt[p*32 +: 32] = disc_cnt_q;
  end

  assign pktout_data     = {PORT_NUM{data_q}};
  assign pktout_data_wr  = data_wr_q;
  assign pktout_valid    = valid_q;
  assign pktout_valid_wr = valid_wr_q;
  assign err_cnt         = err_cnt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/goe_mport.md
GOE_MPORT -- requirements
Module: goe_mport

Interface
REQ-001 The block SHALL have parameter PORT_NUM, default 4, meaning the number of egress ports (legal 2..8).
REQ-002 The block SHALL have parameter USEDW_TH, default 8'd160, meaning the egress FIFO fill level (of 256 words) at or above which a port is full.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_goe_data  in  134  packet word; [133:132] is the tag (01 head, 11 body, 10 tail); head word [111:104] is the destination port bitmap.
REQ-006 in_goe_data_wr  in  1  in_goe_data valid this cycle.
REQ-007 in_goe_valid  in  1  packet-good flag, sampled with in_goe_valid_wr.
REQ-008 in_goe_valid_wr  in  1  end-of-packet status strobe, coincident with the tail word.
REQ-009 pktout_usedw  in  PORT_NUM*8  per-port egress FIFO fill level; port p at [8p+7:8p].
REQ-010 pktout_data  out  PORT_NUM*134  per-port packet word; port p at [134p+133:134p].
REQ-011 pktout_data_wr  out  PORT_NUM  per-port word strobe.
REQ-012 pktout_valid  out  PORT_NUM  per-port packet-good flag.
REQ-013 pktout_valid_wr  out  PORT_NUM  per-port end-of-packet status strobe.
REQ-014 pkt_out_cnt  out  PORT_NUM*32  per-port count of good packets forwarded.
REQ-015 discard_cnt  out  PORT_NUM*32  per-port count of copies dropped because the port was full.
REQ-016 err_cnt  out  32  count of truncated packets (head received with no preceding tail).

Function
REQ-017 The state machine SHALL have three states: IDLE, FWD and DROP.
REQ-018 In IDLE, on data_wr with tag 01, the block SHALL compute mask = bitmap[PORT_NUM-1:0] & ~full, where full[p] = (usedw[p] >= USEDW_TH); bitmap bits at or above PORT_NUM are ignored.
REQ-019 The mask SHALL be latched at the head and held for the whole packet; usedw changes mid-packet SHALL NOT alter it.
REQ-020 If the mask is nonzero, the block SHALL go to FWD; if it is zero, the block SHALL go to DROP.
REQ-021 For every port p with bitmap[p]=1 and full[p]=1, discard_cnt[p] SHALL increment by 1 at the head cycle.
REQ-022 In FWD, every input word, including the head, SHALL appear on pktout_data/data_wr of every masked port with exactly 1 cycle of registered latency.
REQ-023 Unmasked ports SHALL have data_wr=0 in FWD.
REQ-024 pktout_data SHALL be broadcast to all ports; only the strobes are per-port.
REQ-025 valid_wr and valid SHALL be forwarded to masked ports with the same 1-cycle latency.
REQ-026 The tag-10 word SHALL return the state machine to IDLE after that cycle.
REQ-027 pkt_out_cnt[p] SHALL increment when valid_wr=1 and valid=1 is emitted on port p.
REQ-028 When valid=0 is emitted, pkt_out_cnt SHALL NOT increment and the packet SHALL still be forwarded.
REQ-029 In DROP, all words up to and including the tail SHALL be consumed with no output strobes, then the block SHALL return to IDLE.
REQ-030 In IDLE, body or tail words (no head seen) SHALL be ignored with no output strobes and no counter change.
REQ-031 A head word received in FWD SHALL abort the current packet: the next cycle emits valid_wr=1, valid=0 (no data_wr) on the old mask ports.
REQ-032 In the abort case of REQ-031, the new head SHALL be discarded, the block SHALL go to DROP, and err_cnt SHALL increment.
REQ-033 A head word received in DROP SHALL leave the block in DROP and increment err_cnt.
REQ-034 Back-to-back packets SHALL be supported: a head in the cycle after a tail is accepted in IDLE with no bubble.
REQ-035 All counters SHALL be 32-bit and wrap from 0xFFFFFFFF to 0 silently.
REQ-036 Multiple discard_cnt bits SHALL update in the same cycle when several requested ports are full.

Reset
REQ-037 While rst=1, the state SHALL be IDLE, the latched mask SHALL be 0, all output strobes, pktout_data and pktout_valid SHALL be 0, and all counters SHALL be 0.
REQ-038 Reset asserted mid-packet SHALL abandon the packet with no valid_wr emitted.
REQ-039 After reset, remaining words of the abandoned packet SHALL be ignored per REQ-030.

Verification
REQ-040 PORT_NUM=4, usedw all 0, 3-word packet with bitmap 8'b0000_0101 and valid=1 -> ports 0 and 2 each see 3 data_wr pulses, 1 cycle delayed; pkt_out_cnt[0]=pkt_out_cnt[2]=1; ports 1 and 3 stay idle.
REQ-041 Bitmap 8'b0000_0011 with usedw[1]=160 and usedw[0]=159 -> only port 0 forwards; discard_cnt[1]=1.
REQ-042 usedw[1] drops to 0 mid-packet -> port 1 still receives nothing for that packet.
REQ-043 Bitmap 8'b1111_0000 with PORT_NUM=4 -> DROP, no output strobes, no counter change.
REQ-044 Head, body, head, body, tail (no tail before the second head) -> old ports get valid_wr=1, valid=0 the cycle after the second head; err_cnt=1; the rest of the packet is dropped; the next clean packet forwards normally.
REQ-045 discard_cnt[0] preloaded to 0xFFFFFFFF by forcing, then one full-port discard -> reads 0; a reset pulse mid-packet -> all outputs 0 and the tail is ignored.
